seg7_scan_mux: RTL

- Time-multiplexed digit scanner for a common-cathode multi-digit 7-segment display.
- Holds NUM_DIGITS packed 4-bit values and presents one nibble at a time to the downstream binary-to-7-segment decoder, together with the matching one-hot digit select.
- Inserts a blanking interval between digits to prevent ghosting.
- Double-buffers new values so a frame never shows a mix of old and new digits.

---
 rtl/seg7_scan_mux.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed digit scanner for a common-cathode 7-segment display, with a blanking gap
// between digits and double-buffered digit data. Define SEG7_LZ_SUPPRESS_EN for leading-zero blanking.
module seg7_scan_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              nibble_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank_out,
  output logic                    frame_done
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] CntOne       = CntW'(1);
  localparam logic [CntW-1:0] CntBlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] CntSlotLast  = CntW'(PRESCALE - 1);
  localparam logic [IdxW-1:0] IdxOne       = IdxW'(1);
  localparam logic [IdxW-1:0] IdxLast      = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } state_e;

  state_e                  st_q, st_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    pending_q, pending_d;

  logic [3:0]              nib_q, nib_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    blank_q, blank_d;
  logic                    fd_q, fd_d;
  logic                    suppress;

  // Scan sequencing: dropping enable forces idle from any state on the next edge.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    wrap  = 1'b0;
    if (!enable) begin
      st_d  = StIdle;
      cnt_d = '0;
      idx_d = '0;
    end else begin
      case (st_q)
        StIdle: begin
          st_d  = StBlank;
          cnt_d = '0;
          idx_d = '0;
        end
        StBlank: begin
          cnt_d = cnt_q + CntOne;
          if (cnt_q == CntBlankLast) begin
            st_d = StShow;
          end
        end
        StShow: begin
          if (cnt_q == CntSlotLast) begin
            st_d  = StBlank;
            cnt_d = '0;
            if (idx_q == IdxLast) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IdxOne;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          st_d  = StIdle;
          cnt_d = '0;
          idx_d = '0;
        end
      endcase
    end
  end

  // Double buffer: a load at the frame wrap bypasses (and discards) any pending shadow.
  always_comb begin
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    sh_dig_d  = sh_dig_q;
    sh_dp_d   = sh_dp_q;
    pending_d = pending_q;
    if (load) begin
      if (st_q == StIdle) begin
        act_dig_d = digits_in;
        act_dp_d  = dp_in;
      end else if (wrap) begin
        act_dig_d = digits_in;
        act_dp_d  = dp_in;
        pending_d = 1'b0;
      end else begin
        sh_dig_d  = digits_in;
        sh_dp_d   = dp_in;
        pending_d = 1'b1;
      end
    end else if (wrap && pending_q) begin
      act_dig_d = sh_dig_q;
      act_dp_d  = sh_dp_q;
      pending_d = 1'b0;
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  // zero_up[k] is set when digits k..NUM_DIGITS-1 of the next active value are all zero.
  logic [NUM_DIGITS-1:0] zero_up;

  always_comb begin
    zero_up = '0;
    zero_up[NUM_DIGITS-1] = (act_dig_d[4*(NUM_DIGITS-1) +: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_up[k] = (act_dig_d[4*k +: 4] == 4'd0) && zero_up[k+1];
    end
  end

  assign suppress = (idx_d != '0) && zero_up[idx_d] && !act_dp_d[idx_d];
`else
  assign suppress = 1'b0;
`endif

  // Outputs are derived from next-state so the registered values line up with the state.
  always_comb begin
    nib_d   = 4'd0;
    dp_d    = 1'b0;
    sel_d   = '0;
    blank_d = 1'b1;
    fd_d    = wrap;
    if (st_d != StIdle) begin
      nib_d = act_dig_d[4*idx_d +: 4];
      dp_d  = act_dp_d[idx_d];
      if (st_d == StShow && !suppress) begin
        sel_d   = NUM_DIGITS'(1) << idx_d;
        blank_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
      sh_dig_q  <= '0;
      sh_dp_q   <= '0;
      pending_q <= 1'b0;
      nib_q     <= 4'd0;
      dp_q      <= 1'b0;
      sel_q     <= '0;
      blank_q   <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      sh_dig_q  <= sh_dig_d;
      sh_dp_q   <= sh_dp_d;
      pending_q <= pending_d;
      nib_q     <= nib_d;
      dp_q      <= dp_d;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      fd_q      <= fd_d;
    end
  end

  assign nibble_out = nib_q;
  assign dp_out     = dp_q;
  assign digit_sel  = sel_q;
  assign blank_out  = blank_q;
  assign frame_done = fd_q;

endmodule
